// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus shared by the arbiter, its producers and the FIFO write port.
// The master modport is the arbiter; the slave modport is the producers plus FIFO.
interface fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          full;
   logic                          w_en;
   logic [DATA_WIDTH-1:0]         data_in;

   modport master (
      input  req_valid,
      input  req_data,
      input  full,
      output req_ready,
      output w_en,
      output data_in
   );

   modport slave (
      output req_valid,
      output req_data,
      output full,
      input  req_ready,
      input  w_en,
      input  data_in
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each grant costs one IDLE cycle and serves at most MAX_BURST words.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   fifo_wr_arbiter_if.master     bus,
   output logic [2:0]            grant_id,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  xfer_count
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [2:0]            r_rrPtr;
   logic [2:0]            w_nextRrPtr;
   logic [2:0]            r_grantId;
   logic [2:0]            w_nextGrantId;
   logic [3:0]            r_burstCnt;
   logic [3:0]            w_nextBurstCnt;
   logic [CNT_WIDTH-1:0]  r_xferCount;
   logic [CNT_WIDTH-1:0]  w_nextXferCount;

   logic [7:0]            w_validPad;
   logic [7:0]            w_readyPad;
   logic [DATA_WIDTH-1:0] w_dataArr [8];
   logic [2:0]            w_pick;
   logic                  w_pickFound;
   logic                  w_inBurst;
   logic                  w_xfer;
   logic                  w_lastWord;

   // Requester vectors widened to 8 lanes so a 3-bit grant index is always in range
   always_comb begin
      w_validPad = '0;
      for (int i = 0; i < 8; i++) begin
         w_dataArr[i] = '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         w_validPad[i] = bus.req_valid[i];
         w_dataArr[i]  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      w_pick      = '0;
      w_pickFound = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = int'(r_rrPtr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!w_pickFound && w_validPad[idx[2:0]]) begin
            w_pick      = idx[2:0];
            w_pickFound = 1'b1;
         end
      end
   end

   assign w_inBurst  = wrst_n && (r_state == BURST);
   assign w_xfer     = w_inBurst && w_validPad[r_grantId] && !bus.full;
   assign w_lastWord = (r_burstCnt == 4'(MAX_BURST - 1));

   always_comb begin
      w_readyPad = '0;
      if (w_xfer) begin
         w_readyPad[r_grantId] = 1'b1;
      end
   end

   assign bus.req_ready = w_readyPad[NUM_REQ-1:0];
   assign bus.w_en      = w_xfer;
   assign bus.data_in   = w_inBurst ? w_dataArr[r_grantId] : '0;
   assign busy          = w_inBurst;
   assign grant_id      = r_grantId;
   assign xfer_count    = r_xferCount;

   // Next-state logic; leaving BURST always advances the pointer past the grantee
   always_comb begin
      w_nextState     = r_state;
      w_nextRrPtr     = r_rrPtr;
      w_nextGrantId   = r_grantId;
      w_nextBurstCnt  = r_burstCnt;
      w_nextXferCount = r_xferCount;
      case (r_state)
         IDLE: begin
            if (w_pickFound) begin
               w_nextState    = BURST;
               w_nextGrantId  = w_pick;
               w_nextBurstCnt = '0;
            end
         end
         BURST: begin
            if (w_xfer) begin
               w_nextBurstCnt  = r_burstCnt + 4'd1;
               w_nextXferCount = r_xferCount + CNT_WIDTH'(1);
            end
            if ((w_xfer && w_lastWord) || !w_validPad[r_grantId]) begin
               w_nextState = IDLE;
               w_nextRrPtr = (r_grantId == 3'(NUM_REQ - 1)) ? 3'd0 : r_grantId + 3'd1;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         r_state     <= IDLE;
         r_rrPtr     <= '0;
         r_grantId   <= '0;
         r_burstCnt  <= '0;
         r_xferCount <= '0;
      end else begin
         r_state     <= w_nextState;
         r_rrPtr     <= w_nextRrPtr;
         r_grantId   <= w_nextGrantId;
         r_burstCnt  <= w_nextBurstCnt;
         r_xferCount <= w_nextXferCount;
      end
   end

   // Handshake invariants the FIFO relies on
   assert property (@(posedge wclk) $onehot0(bus.req_ready));
   assert property (@(posedge wclk) bus.w_en |-> !bus.full);
   assert property (@(posedge wclk) bus.w_en == |(bus.req_valid & bus.req_ready));
   assert property (@(posedge wclk) !wrst_n |-> !bus.w_en);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against
// a rule-level model of the arbitration and a queue standing in for the FIFO.
module tb_fifo_wr_arbiter;
   localparam int NREQ = 4;
   localparam int MAXB = 4;

   logic        wclk;
   logic        wrst_n;
   logic [2:0]  grant_id;
   logic        busy;
   logic [15:0] xfer_count;

   fifo_wr_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(NREQ)) bus ();

   fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(NREQ), .MAX_BURST(MAXB), .CNT_WIDTH(16)) dut (
      .wclk       (wclk),
      .wrst_n     (wrst_n),
      .bus        (bus),
      .grant_id   (grant_id),
      .busy       (busy),
      .xfer_count (xfer_count)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int checks = 0;
   int errors = 0;

   logic [3:0]  drvValid = '0;
   logic [31:0] drvData  = '0;
   logic        drvFull  = 1'b0;
   logic        drvRst   = 1'b0;

   bit          mInBurst = 1'b0;
   int          mGrant   = 0;
   int          mRr      = 0;
   int          mBurst   = 0;
   int unsigned mCount   = 0;

   logic [3:0]  expReady;
   logic        expWen;
   logic [7:0]  expData;
   logic        expBusy;
   logic [2:0]  expGrant;
   logic [3:0]  obsReady;
   logic        obsWen;
   logic [7:0]  obsData;
   logic        obsBusy;
   logic [2:0]  obsGrant;
   logic [15:0] obsCount;
   logic [2:0]  obsGrantAfter;

   // One clock: drive inputs, predict from the rules, sample mid-cycle, advance the model
   task automatic tick();
      bit          nIn;
      int          nGrant, nRr, nBurst;
      int unsigned nCount;
      bit          leave;
      bus.req_valid = drvValid;
      bus.req_data  = drvData;
      bus.full      = drvFull;
      wrst_n        = drvRst;
      #3;
      nIn = mInBurst; nGrant = mGrant; nRr = mRr; nBurst = mBurst; nCount = mCount;
      leave    = 1'b0;
      expReady = '0; expWen = 1'b0; expData = '0; expBusy = 1'b0;
      expGrant = 3'(mGrant);
      if (!drvRst) begin
         nIn = 1'b0; nGrant = 0; nRr = 0; nBurst = 0; nCount = 0;
      end else if (!mInBurst) begin
         for (int k = NREQ - 1; k >= 0; k--) begin
            if (drvValid[(mRr + k) % NREQ]) begin
               nGrant = (mRr + k) % NREQ;
               nIn    = 1'b1;
               nBurst = 0;
            end
         end
      end else begin
         expBusy = 1'b1;
         expData = drvData[mGrant*8 +: 8];
         if (drvValid[mGrant] && !drvFull) begin
            expReady = 4'(1 << mGrant);
            expWen   = 1'b1;
            nCount   = (mCount + 1) % 65536;
            nBurst   = mBurst + 1;
            leave    = (nBurst == MAXB);
         end else if (!drvValid[mGrant]) begin
            leave = 1'b1;
         end
         if (leave) begin
            nIn = 1'b0;
            nRr = (mGrant + 1) % NREQ;
         end
      end
      obsReady = bus.req_ready;
      obsWen   = bus.w_en;
      obsData  = bus.data_in;
      obsBusy  = busy;
      obsGrant = grant_id;
      @(posedge wclk);
      #1;
      mInBurst = nIn; mGrant = nGrant; mRr = nRr; mBurst = nBurst; mCount = nCount;
      obsCount      = xfer_count;
      obsGrantAfter = grant_id;
   endtask

   task automatic doReset();
      drvRst = 1'b0; drvValid = '0; drvFull = 1'b0; drvData = '0;
      tick();
      tick();
      drvRst = 1'b1;
   endtask

   task automatic test_reset();
      drvRst = 1'b0; drvValid = 4'b1111; drvFull = 1'b0; drvData = 32'h44332211;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (obsWen !== 1'b0 || obsReady !== 4'b0000 || obsBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs cyc %0d got w_en=%b ready=%b busy=%b want 0/0000/0", c, obsWen, obsReady, obsBusy);
         end
         checks++;
         if (obsData !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data got %h want 00", obsData);
         end
      end
      checks++;
      if (obsCount !== 16'd0 || obsGrantAfter !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_state got count=%0d grant=%0d want 0/0", obsCount, obsGrantAfter);
      end
      drvRst = 1'b1;
   endtask

   task automatic test_single();
      int seq = 1;
      int got[$];
      doReset();
      drvValid = 4'b0001;
      for (int c = 0; c < 11; c++) begin
         drvData = {24'd0, 8'(seq)};
         tick();
         checks++;
         if (obsWen !== expWen || obsData !== expData) begin
            errors++;
            $display("[TB] FAIL single_xfer cyc %0d got w_en=%b data=%h want %b/%h", c, obsWen, obsData, expWen, expData);
         end
         if (obsWen) begin
            got.push_back(int'(obsData));
            seq++;
         end
         if (c == 4) begin
            checks++;
            if (obsCount !== 16'd4) begin
               errors++;
               $display("[TB] FAIL single_count got %0d want 4", obsCount);
            end
         end
         if (c == 5) begin
            checks++;
            if (obsBusy !== 1'b0 || obsWen !== 1'b0) begin
               errors++;
               $display("[TB] FAIL single_bubble got busy=%b w_en=%b want 0/0", obsBusy, obsWen);
            end
         end
         if (c == 6) begin
            checks++;
            if (obsBusy !== 1'b1 || obsGrant !== 3'd0) begin
               errors++;
               $display("[TB] FAIL single_regrant got busy=%b grant=%0d want 1/0", obsBusy, obsGrant);
            end
         end
      end
      checks++;
      if (got.size() != 8) begin
         errors++;
         $display("[TB] FAIL single_words got %0d words want 8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] != i + 1) begin
               errors++;
               $display("[TB] FAIL single_order idx %0d got %0d want %0d", i, got[i], i + 1);
            end
         end
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      logic prevBusy = 1'b0;
      doReset();
      drvValid = 4'b1111;
      for (int c = 0; c < 22; c++) begin
         drvData = $urandom;
         tick();
         checks++;
         if (obsReady !== expReady || obsWen !== expWen) begin
            errors++;
            $display("[TB] FAIL rr_ready cyc %0d got %b/%b want %b/%b", c, obsReady, obsWen, expReady, expWen);
         end
         if (obsBusy && !prevBusy) order.push_back(int'(obsGrant));
         prevBusy = obsBusy;
         if (c == 19) begin
            checks++;
            if (obsCount !== 16'd16) begin
               errors++;
               $display("[TB] FAIL rr_count got %0d want 16", obsCount);
            end
         end
      end
      checks++;
      if (order.size() != 5) begin
         errors++;
         $display("[TB] FAIL rr_grants got %0d grants want 5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (order[i] != i % NREQ) begin
               errors++;
               $display("[TB] FAIL rr_order idx %0d got %0d want %0d", i, order[i], i % NREQ);
            end
         end
      end
   endtask

   task automatic test_full_stall();
      int words = 0;
      doReset();
      drvValid = 4'b1100;
      for (int c = 0; c < 12; c++) begin
         drvFull = (c >= 3 && c <= 7);
         drvData = {8'h30 + 8'(words), 8'h20 + 8'(words), 16'h0000};
         tick();
         if (obsWen) words++;
         if (drvFull) begin
            checks++;
            if (obsWen !== 1'b0 || obsReady !== 4'b0000 || obsGrant !== 3'd2 || obsBusy !== 1'b1) begin
               errors++;
               $display("[TB] FAIL stall_hold cyc %0d got w_en=%b ready=%b grant=%0d busy=%b want 0/0000/2/1", c, obsWen, obsReady, obsGrant, obsBusy);
            end
         end
         if (c == 9) begin
            checks++;
            if (words != 4 || obsData !== 8'h23) begin
               errors++;
               $display("[TB] FAIL stall_resume got words=%0d data=%h want 4/23", words, obsData);
            end
         end
         if (c == 11) begin
            checks++;
            if (obsGrant !== 3'd3 || obsWen !== 1'b1) begin
               errors++;
               $display("[TB] FAIL stall_next got grant=%0d w_en=%b want 3/1", obsGrant, obsWen);
            end
         end
      end
      drvFull = 1'b0;
   endtask

   task automatic test_drop_valid();
      doReset();
      for (int c = 0; c < 5; c++) begin
         drvValid = (c < 2) ? 4'b1010 : 4'b1000;
         drvData  = $urandom;
         tick();
         if (c == 1) begin
            checks++;
            if (obsGrant !== 3'd1 || obsWen !== 1'b1) begin
               errors++;
               $display("[TB] FAIL drop_first got grant=%0d w_en=%b want 1/1", obsGrant, obsWen);
            end
         end
         if (c == 3) begin
            checks++;
            if (obsBusy !== 1'b0) begin
               errors++;
               $display("[TB] FAIL drop_idle got busy=%b want 0", obsBusy);
            end
         end
         if (c == 4) begin
            checks++;
            if (obsGrant !== 3'd3 || obsReady !== 4'b1000) begin
               errors++;
               $display("[TB] FAIL drop_next got grant=%0d ready=%b want 3/1000", obsGrant, obsReady);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      doReset();
      drvValid = 4'b0100;
      for (int c = 0; c < 8; c++) begin
         drvData = $urandom;
         tick();
      end
      checks++;
      if (obsCount !== 16'd6 || obsGrantAfter !== 3'd2) begin
         errors++;
         $display("[TB] FAIL mid_setup got count=%0d grant=%0d want 6/2", obsCount, obsGrantAfter);
      end
      drvRst = 1'b0;
      tick();
      checks++;
      if (obsWen !== 1'b0 || obsReady !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL mid_wen got w_en=%b ready=%b want 0/0000", obsWen, obsReady);
      end
      checks++;
      if (obsCount !== 16'd0 || obsGrantAfter !== 3'd0) begin
         errors++;
         $display("[TB] FAIL mid_state got count=%0d grant=%0d want 0/0", obsCount, obsGrantAfter);
      end
      drvRst = 1'b1;
      tick();
      checks++;
      if (obsBusy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_idle got busy=%b want 0", obsBusy);
      end
   endtask

   task automatic test_fifo();
      logic [7:0] fifoQ[$];
      int seqs[NREQ];
      int badWrites = 0;
      doReset();
      drvValid = 4'b1111;
      for (int i = 0; i < NREQ; i++) seqs[i] = 0;
      for (int c = 0; c < 20; c++) begin
         drvFull = (fifoQ.size() >= 8);
         for (int i = 0; i < NREQ; i++) drvData[i*8 +: 8] = 8'((i << 4) | seqs[i]);
         tick();
         if (obsWen) begin
            if (drvFull) badWrites++;
            fifoQ.push_back(obsData);
            for (int i = 0; i < NREQ; i++) if (obsReady[i]) seqs[i]++;
         end
      end
      checks++;
      if (badWrites != 0 || fifoQ.size() != 8) begin
         errors++;
         $display("[TB] FAIL fifo_fill got %0d words %0d writes-while-full want 8/0", fifoQ.size(), badWrites);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (fifoQ[i] !== 8'(((i / MAXB) << 4) | (i % MAXB))) begin
               errors++;
               $display("[TB] FAIL fifo_order idx %0d got %h want %h", i, fifoQ[i], 8'(((i / MAXB) << 4) | (i % MAXB)));
            end
         end
      end
      drvFull = 1'b0;
   endtask

   task automatic test_random();
      doReset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(4, 0) == 0) drvValid = 4'($urandom);
         drvData = $urandom;
         drvFull = ($urandom_range(3, 0) == 0);
         drvRst  = ($urandom_range(59, 0) != 0);
         tick();
         checks++;
         if (obsReady !== expReady || obsWen !== expWen || obsBusy !== expBusy) begin
            errors++;
            $display("[TB] FAIL rand_hs cyc %0d got ready=%b w_en=%b busy=%b want %b/%b/%b", c, obsReady, obsWen, obsBusy, expReady, expWen, expBusy);
         end
         checks++;
         if (obsData !== expData || obsGrant !== expGrant) begin
            errors++;
            $display("[TB] FAIL rand_data cyc %0d got data=%h grant=%0d want %h/%0d", c, obsData, obsGrant, expData, expGrant);
         end
         checks++;
         if (obsCount !== 16'(mCount)) begin
            errors++;
            $display("[TB] FAIL rand_count cyc %0d got %0d want %0d", c, obsCount, mCount);
         end
      end
      drvRst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full_stall();
      test_drop_valid();
      test_reset_mid();
      test_fifo();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before the test sequence completed");
      $fatal(1, "[TB] watchdog");
   end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side arbiter that shares the single write port of the team's asynchronous FIFO (8-bit data, 8 entries) among NUM_REQ producers.
- Sits in the FIFO write-clock domain. Drives the FIFO w_en/data_in directly and obeys the FIFO's full flag.
- Round-robin grants with a per-grant burst cap (MAX_BURST), so no producer can monopolise the FIFO.
- Keeps a running count of accepted words.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO data_in width.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum words accepted per grant (1..15).
- CNT_WIDTH, 16, width of the accepted-word counter.

Ports:
- wclk, in, 1, write-domain clock; all state updates on rising edge.
- wrst_n, in, 1, synchronous active-low reset, sampled on rising wclk.
- req_valid, in, NUM_REQ, per-requester data-valid.
- req_data, in, NUM_REQ*DATA_WIDTH, packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready, out, NUM_REQ, per-requester accept; a word transfers when req_valid[i] && req_ready[i].
- full, in, 1, FIFO full flag (write domain).
- w_en, out, 1, FIFO write enable.
- data_in, out, DATA_WIDTH, FIFO write data.
- grant_id, out, 3, index of the current/last grantee.
- busy, out, 1, high while in BURST.
- xfer_count, out, CNT_WIDTH, total accepted words.

Behaviour:
- Interface: one clock (wclk); reset is synchronous and active-low (wrst_n).
- Reset (wrst_n=0 at an edge):
  - state=IDLE; rr_ptr=0; grant_id=0; burst_cnt=0; xfer_count=0.
  - While wrst_n=0, w_en, req_ready and busy are forced 0 combinationally.
  - data_in = 0 in IDLE and during reset.
- FSM, 2 states: IDLE, BURST.
- IDLE:
  - If any req_valid is set, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register that index into grant_id, clear burst_cnt, go to BURST.
  - Arbitration costs exactly 1 cycle. No transfers occur in IDLE.
- BURST:
  - req_ready[grant_id] = req_valid[grant_id] && !full. All other req_ready bits are 0.
  - w_en = req_ready[grant_id]; data_in = req_data slice of grant_id (combinational mux).
  - On each transfer: burst_cnt+1 and xfer_count+1. xfer_count wraps modulo 2^CNT_WIDTH.
- Exit BURST to IDLE when either:
  - a transfer occurs with burst_cnt==MAX_BURST-1, or
  - req_valid[grant_id]=0 in that cycle (no transfer).
- On exit: rr_ptr = (grant_id+1) mod NUM_REQ; grant_id holds its value.
- full=1 while in BURST: no transfer, stay in BURST, burst_cnt and xfer_count hold.
  - A full-stalled grantee keeps its grant until full drops, or it drops valid.
- Throughput: at most MAX_BURST words per MAX_BURST+1 cycles (one IDLE bubble per grant).
- Requesters may deassert valid at any time without penalty beyond losing the grant.
- Simultaneous valids: only the round-robin winner is served; the others wait with ready=0.
- Reset mid-burst: the burst is abandoned at the reset edge. The FIFO never sees w_en while wrst_n=0.
- Invariants:
  - $onehot0(req_ready).
  - w_en implies !full.
  - w_en == |(req_valid & req_ready).

Test Plan:
- Reset, then req_valid=4'b0001 steady with data 1,2,3,... and full=0 -> grant_id=0. Words 1–4 accepted on consecutive cycles, then 1 IDLE cycle, then re-granted to 0. xfer_count=4 after the first burst.
- req_valid=4'b1111 steady, full=0 -> grant order 0,1,2,3,0. Each burst is 4 words. Exactly 1 IDLE cycle between bursts. xfer_count=16 after 20 cycles in BURST/IDLE.
- Requester 2 granted, full rises after 2 words for 5 cycles -> w_en=0 and req_ready=0 for those 5 cycles. grant_id stays 2. After full falls, words 3–4 are accepted, then next grant.
- Requester 1 granted, drops valid after 1 word, while requester 3 is valid -> exit to IDLE. rr_ptr=2. Next grant is 3, not 1.
- Assert wrst_n=0 for 1 cycle mid-burst with xfer_count=6 -> at the next edge: state IDLE, xfer_count=0, grant_id=0. w_en is 0 during reset.
- Drive a real FIFO instance: 4 requesters, each writing distinct tagged data, until full -> exactly 8 words stored with no writes while full. Data order matches grant order.
